// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, start, 8 data bits LSB-first, odd parity, stop, device ACK.
// Latency: device clock fall to data change is 3 cycles, and done_out comes 3 cycles after both lines go idle.
// Backpressure: one byte in flight; valid_in is taken only while ready_out is high. PS2_HOST_TX_TIMEOUT_EN enables the watchdog.
module ps2_host_tx #(
  parameter int CLK_PERIOD_NS    = 13,
  parameter int INHIBIT_US       = 120,
  parameter int START_TIMEOUT_US = 15000,
  parameter int BIT_TIMEOUT_US   = 2000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       ack_out,
  output logic       error_out,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_low_out,
  output logic       ps2_data_low_out
);

  localparam int INHIBIT_CYCLES = INHIBIT_US * 1000 / CLK_PERIOD_NS;
  localparam int INH_W          = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, START, REQ, BITS, WAIT_IDLE} state_t;

  state_t           state;
  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             clk_prev;
  logic             fall;
  logic             lines_idle;
  logic             wd_expired;
  logic [9:0]       frame;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;

  // Sync flops reset to 1 so an idle (pulled-up) bus never looks like a falling edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall       = clk_prev & ~clk_sync[1];
  assign lines_idle = clk_sync[1] & data_sync[1];

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int START_CYCLES = START_TIMEOUT_US * 1000 / CLK_PERIOD_NS;
  localparam int BIT_CYCLES   = BIT_TIMEOUT_US * 1000 / CLK_PERIOD_NS;
  localparam int WD_MAX       = (START_CYCLES > BIT_CYCLES) ? START_CYCLES : BIT_CYCLES;
  localparam int WD_W         = $clog2(WD_MAX + 1);

  logic [WD_W-1:0] wd_cnt;

  // Loaded one cycle ahead of REQ so expiry lands exactly START_CYCLES after clock release.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wd_cnt <= '0;
    end else if (state == START) begin
      wd_cnt <= WD_W'(START_CYCLES - 1);
    end else if (fall && (state == REQ || state == BITS)) begin
      wd_cnt <= WD_W'(BIT_CYCLES - 1);
    end else if (wd_cnt != '0) begin
      wd_cnt <= wd_cnt - 1'b1;
    end
  end

  assign wd_expired = (wd_cnt == '0) && (state == REQ || state == BITS || state == WAIT_IDLE);
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= IDLE;
      frame            <= '0;
      bit_cnt          <= '0;
      inh_cnt          <= '0;
      ps2_clk_low_out  <= 1'b0;
      ps2_data_low_out <= 1'b0;
      ready_out        <= 1'b1;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
      ack_out          <= 1'b0;
      error_out        <= 1'b0;
    end else begin
      done_out  <= 1'b0;
      error_out <= 1'b0;
      case (state)
        IDLE: begin
          ready_out <= 1'b1;
          busy_out  <= 1'b0;
          if (valid_in && ready_out) begin
            frame           <= {1'b1, ~^data_in, data_in};
            ack_out         <= 1'b0;
            inh_cnt         <= '0;
            bit_cnt         <= '0;
            ps2_clk_low_out <= 1'b1;
            ready_out       <= 1'b0;
            busy_out        <= 1'b1;
            state           <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            ps2_data_low_out <= 1'b1;
            state            <= START;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        START: begin
          ps2_clk_low_out <= 1'b0;
          state           <= REQ;
        end
        REQ: begin
          if (fall) begin
            ps2_data_low_out <= ~frame[0];
            bit_cnt          <= 4'd1;
            state            <= BITS;
          end else if (wd_expired) begin
            ps2_clk_low_out  <= 1'b0;
            ps2_data_low_out <= 1'b0;
            error_out        <= 1'b1;
            state            <= IDLE;
          end
        end
        BITS: begin
          // An edge arriving in the expiry cycle still counts as progress.
          if (fall) begin
            if (bit_cnt == 4'd10) begin
              ack_out <= ~data_sync[1];
              state   <= WAIT_IDLE;
            end else begin
              ps2_data_low_out <= ~frame[bit_cnt];
              bit_cnt          <= bit_cnt + 1'b1;
            end
          end else if (wd_expired) begin
            ps2_clk_low_out  <= 1'b0;
            ps2_data_low_out <= 1'b0;
            error_out        <= 1'b1;
            state            <= IDLE;
          end
        end
        WAIT_IDLE: begin
          if (lines_idle) begin
            done_out <= 1'b1;
            state    <= IDLE;
          end else if (wd_expired) begin
            ps2_clk_low_out  <= 1'b0;
            ps2_data_low_out <= 1'b0;
            error_out        <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboarded bench for ps2_host_tx with an open-drain PS/2 device model and a frame reference model.
module tb_ps2_host_tx;

  localparam int CLK_NS   = 1000;
  localparam int INH_US   = 20;
  localparam int START_US = 400;
  localparam int BIT_US   = 200;
  localparam int N_INH    = INH_US * 1000 / CLK_NS;
  localparam int S_CYC    = START_US * 1000 / CLK_NS;
  localparam int B_CYC    = BIT_US * 1000 / CLK_NS;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out, busy_out, done_out, ack_out, error_out;
  logic       ps2_clk_low_out, ps2_data_low_out;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = !ps2_clk_low_out && !dev_clk_low;
  assign ps2_data_line = !ps2_data_low_out && !dev_data_low;

  ps2_host_tx #(
    .CLK_PERIOD_NS(CLK_NS), .INHIBIT_US(INH_US),
    .START_TIMEOUT_US(START_US), .BIT_TIMEOUT_US(BIT_US)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .busy_out(busy_out), .done_out(done_out), .ack_out(ack_out),
    .error_out(error_out), .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
    .ps2_clk_low_out(ps2_clk_low_out), .ps2_data_low_out(ps2_data_low_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference frame as the device sees it: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ($countones(d) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  typedef struct {
    logic [7:0] d;
    bit         is_err;
    bit         ack;
    int         kind;  // 0: start timeout, 1: bit timeout
  } exp_t;

  exp_t         exp_q[$];
  int           dev_mode_q[$];
  logic [7:0]   dev_byte_q[$];
  int           dev_h = 30;
  logic [10:0]  dev_frame = '0;
  int           dev_fall_cyc = 0;
  int           dev_rel_cyc = 0;
  int           dev_falls = 0;
  int           clk_rel_cyc = 0;

  // Device model. Modes: 0 ack, 1 no ack, 2 never clocks, 3 stalls after 4 falls, 4 gap of exactly B_CYC before fall 5.
  initial begin : device
    int mode, h, hi;
    logic [7:0] db;
    forever begin
      @(negedge clk_in);
      if (!ps2_clk_line) begin
        while (!(ps2_clk_line && !ps2_data_line)) @(negedge clk_in);
        mode = (dev_mode_q.size() != 0) ? dev_mode_q.pop_front() : 0;
        db   = (dev_byte_q.size() != 0) ? dev_byte_q.pop_front() : 8'h00;
        h    = dev_h;
        dev_falls = 0;
        dev_frame[0] = ps2_data_line;
        for (int k = 1; k <= 11; k++) begin
          if (mode == 2 || (mode == 3 && k == 5)) break;
          hi = (mode == 4 && k == 5) ? (B_CYC - h) : h;
          for (int c = 0; c < hi; c++) begin
            @(negedge clk_in);
            if (k == 11 && mode != 1 && c == hi / 2) dev_data_low = 1'b1;
          end
          dev_clk_low  = 1'b1;
          dev_fall_cyc = cyc;
          dev_falls++;
          if (k == 1) begin
            repeat (2) @(negedge clk_in);
            chk("bit0_start_held", ps2_data_low_out, 1);
            @(negedge clk_in);
            chk("bit0_latency", ps2_data_low_out, !db[0]);
            repeat (h - 3) @(negedge clk_in);
          end else begin
            repeat (h) @(negedge clk_in);
          end
          dev_clk_low = 1'b0;
          if (k <= 10) begin
            dev_frame[k] = ps2_data_line;
          end else begin
            dev_data_low = 1'b0;
            dev_rel_cyc  = cyc;
          end
        end
      end
    end
  end

  // Request-to-send line timing.
  logic prev_clk_low = 1'b0, prev_data_low = 1'b0, armed = 1'b0;
  int   rise_cyc = 0;
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (ps2_clk_low_out && !prev_clk_low) begin
        rise_cyc = cyc;
        armed    = 1'b1;
      end
      if (ps2_data_low_out && !prev_data_low && armed) begin
        chk("inhibit_length", cyc - rise_cyc, N_INH);
        armed = 1'b0;
      end
      if (!ps2_clk_low_out && prev_clk_low) begin
        chk("clk_release", cyc - rise_cyc, N_INH + 1);
        clk_rel_cyc = cyc;
      end
    end
    prev_clk_low  = ps2_clk_low_out;
    prev_data_low = ps2_data_low_out;
  end

  // Scoreboard monitor: every done/error pulse consumes one expected entry.
  exp_t me;
  always begin
    @(negedge clk_in);
    if (rst_n_in && (done_out || error_out)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {done_out, error_out}, 0);
      end else begin
        me = exp_q.pop_front();
        chk("event_kind", error_out, me.is_err);
        chk("event_exclusive", done_out & error_out, 0);
        if (!me.is_err) begin
          chk("ack", ack_out, me.ack);
          chk("frame", dev_frame, frame_of(me.d));
          chk("done_latency", cyc - dev_rel_cyc, 3);
        end else begin
          chk("err_latency", cyc - ((me.kind == 0) ? clk_rel_cyc : dev_fall_cyc),
              (me.kind == 0) ? S_CYC : B_CYC + 3);
          chk("err_release", {ps2_clk_low_out, ps2_data_low_out}, 0);
        end
        chk("ready_during_event", ready_out, 0);
        @(negedge clk_in);
        chk("event_pulse_width", {done_out, error_out}, 0);
        chk("ready_after_event", ready_out, 1);
      end
    end
  end

  task automatic send(input logic [7:0] d, input int mode, input bit push,
                      input bit is_err, input bit ack, input int kind);
    exp_t e;
    int w = 0;
    @(negedge clk_in);
    while (!ready_out && w < 2000) begin
      @(negedge clk_in);
      w++;
    end
    chk("send_ready", ready_out, 1);
    data_in  = d;
    valid_in = 1'b1;
    dev_mode_q.push_back(mode);
    dev_byte_q.push_back(d);
    if (push) begin
      e.d = d; e.is_err = is_err; e.ack = ack; e.kind = kind;
      exp_q.push_back(e);
    end
    @(posedge clk_in);
    @(negedge clk_in);
    chk("accept_clk_low", ps2_clk_low_out, 1);
    chk("accept_busy", busy_out, 1);
    valid_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int w = 0;
    do begin
      @(negedge clk_in);
      w++;
    end while (!(exp_q.size() == 0 && ready_out) && w < 3000);
    chk(name, (exp_q.size() == 0 && ready_out), 1);
    repeat (5) @(negedge clk_in);
  endtask

  task automatic pulse_reset();
    @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    chk("rst_clk_low_async", ps2_clk_low_out, 0);
    chk("rst_data_low_async", ps2_data_low_out, 0);
    chk("rst_busy_async", busy_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("rst_ready_after", ready_out, 1);
    chk("rst_busy_after", busy_out, 0);
  endtask

  initial begin : watchdog
    #(10 * 60000);
    $display("FAIL global_timeout actual=%0d required=finished", cyc);
    $fatal(1);
  end

  initial begin : stimulus
    logic [7:0] d;
    int         m, w, dcyc;
    exp_t       e;

    repeat (3) @(negedge clk_in);
    chk("reset_clk_low", ps2_clk_low_out, 0);
    chk("reset_data_low", ps2_data_low_out, 0);
    chk("reset_ready", ready_out, 1);
    chk("reset_busy", busy_out, 0);
    chk("reset_done", done_out, 0);
    chk("reset_ack", ack_out, 0);
    chk("reset_error", error_out, 0);
    rst_n_in = 1'b1;
    repeat (3) @(negedge clk_in);

    dev_h = 30;
    send(8'hED, 0, 1, 0, 1, 0); wait_idle("idle_ed");
    send(8'h00, 0, 1, 0, 1, 0); wait_idle("idle_00");
    send(8'hFF, 1, 1, 0, 0, 0); wait_idle("idle_ff_noack");

    for (int i = 0; i < 6; i++) begin
      d     = 8'($urandom_range(0, 255));
      m     = $urandom_range(0, 1);
      dev_h = $urandom_range(20, 40);
      send(d, m, 1, 0, (m == 0), 0);
      wait_idle("idle_random");
    end

    dev_h = 30;
    send(8'($urandom_range(0, 255)), 4, 1, 0, 1, 0);
    wait_idle("idle_edge_wins");

`ifdef PS2_HOST_TX_TIMEOUT_EN
    send(8'hF4, 2, 1, 1, 0, 0); wait_idle("idle_start_timeout");
    send(8'($urandom_range(0, 255)), 3, 1, 1, 0, 1); wait_idle("idle_bit_timeout");
`else
    send(8'hF4, 2, 0, 0, 0, 0);
    repeat (S_CYC + 50) @(negedge clk_in);
    chk("hang_busy", busy_out, 1);
    chk("hang_clk_released", ps2_clk_low_out, 0);
    chk("hang_start_bit", ps2_data_low_out, 1);
    pulse_reset();
`endif

    // Reset mid-BITS: bit 3 forced to 0 so the data line is actively driven when reset hits.
    d = 8'($urandom_range(0, 255)) & 8'hF7;
    send(d, 3, 0, 0, 0, 0);
    w = 0;
    while (dev_falls < 4 && w < 2000) begin
      @(negedge clk_in);
      w++;
    end
    chk("rst_reached_bits", (dev_falls >= 4), 1);
    repeat (dev_h + 10) @(negedge clk_in);
    chk("rst_pre_data_low", ps2_data_low_out, 1);
    pulse_reset();
    repeat (5) @(negedge clk_in);
    send(8'($urandom_range(0, 255)), 0, 1, 0, 1, 0); wait_idle("idle_after_reset");

    // valid_in held through a transfer: the second byte waits for done_out.
    @(negedge clk_in);
    while (!ready_out) @(negedge clk_in);
    d = 8'($urandom_range(0, 255));
    data_in  = d;
    valid_in = 1'b1;
    dev_mode_q.push_back(0);
    dev_byte_q.push_back(d);
    e.d = d; e.is_err = 1'b0; e.ack = 1'b1; e.kind = 0;
    exp_q.push_back(e);
    @(posedge clk_in);
    @(negedge clk_in);
    d = ~d;
    data_in = d;
    dev_mode_q.push_back(0);
    dev_byte_q.push_back(d);
    e.d = d;
    exp_q.push_back(e);
    w = 0;
    while (!done_out && w < 3000) begin
      @(negedge clk_in);
      w++;
    end
    chk("hold_first_done", done_out, 1);
    dcyc = cyc;
    w = 0;
    while (!ps2_clk_low_out && w < 20) begin
      @(negedge clk_in);
      w++;
    end
    chk("hold_accept_gap", cyc - dcyc, 2);
    valid_in = 1'b0;
    wait_idle("idle_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
